// File: rtl/div_bcd_readout.sv
// Captures the divider's quotient/remainder and converts both to packed BCD
// with a serial double-dabble engine for the seven-segment display driver.
module div_bcd_readout #(
  parameter int unsigned N      = 4,
  parameter int unsigned DIGITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_done,
  input  logic                in_error,
  input  logic [N-1:0]        q,
  input  logic [N-1:0]        r,
  output logic                busy,
  output logic                out_valid,
  output logic                out_error,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t          state;
  logic            done_d;
  logic            err_d;
  logic [CW-1:0]   count;
  logic [BW-1:0]   q_acc;
  logic [BW-1:0]   r_acc;
  logic [N-1:0]    q_bin;
  logic [N-1:0]    r_bin;
  logic [BW-1:0]   q_adj;
  logic [BW-1:0]   r_adj;
  logic [BW-1:0]   q_acc_nx;
  logic [BW-1:0]   r_acc_nx;
  logic            start;
  logic            fault;

  // Add 3 to every BCD digit that is 5 or more, ahead of the shift
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
    logic [BW-1:0] t;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return t;
  endfunction

  // Rising-edge detection of the divider flags; error suppresses start
  assign start = in_done & ~done_d & ~in_error;
  assign fault = in_error & ~err_d;

  // One double-dabble step for both paths: adjust, then shift binary MSB in
  always_comb begin
    q_adj    = add3(q_acc);
    r_adj    = add3(r_acc);
    q_acc_nx = {q_adj[BW-2:0], q_bin[N-1]};
    r_acc_nx = {r_adj[BW-2:0], r_bin[N-1]};
  end

  // Control FSM, conversion datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      done_d    <= 1'b0;
      err_d     <= 1'b0;
      count     <= '0;
      q_acc     <= '0;
      r_acc     <= '0;
      q_bin     <= '0;
      r_bin     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      q_bcd     <= '0;
      r_bcd     <= '0;
    end else begin
      done_d <= in_done;
      err_d  <= in_error;
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_error <= 1'b0;
          if (fault) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_error <= 1'b1;
            q_bcd     <= '1;
            r_bcd     <= '1;
          end else if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            q_bin <= q;
            r_bin <= r;
            q_acc <= '0;
            r_acc <= '0;
            count <= CW'(N);
          end
        end
        SHIFT: begin
          q_acc <= q_acc_nx;
          r_acc <= r_acc_nx;
          q_bin <= {q_bin[N-2:0], 1'b0};
          r_bin <= {r_bin[N-2:0], 1'b0};
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_error <= 1'b0;
            q_bcd     <= q_acc_nx;
            r_bcd     <= r_acc_nx;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          if (!in_done && !in_error) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_error <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_readout.sv
// Bench for div_bcd_readout: vector table plus corner-case sequences,
// N=4/DIGITS=2 instance with scoreboard, N=8/DIGITS=3 instance checked inline.
module tb_div_bcd_readout;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_done, in_error;
  logic [3:0] q, r;
  logic       busy, out_valid, out_error;
  logic [7:0] q_bcd, r_bcd;

  logic        in_done8, in_error8;
  logic [7:0]  q8, r8;
  logic        busy8, out_valid8, out_error8;
  logic [11:0] q_bcd8, r_bcd8;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic ov_prev = 1'b0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic [7:0] eq;
    logic [7:0] er;
  } vec_t;

  typedef struct {
    logic [7:0] eq;
    logic [7:0] er;
    logic       err;
  } sb_t;

  vec_t vecs[6];
  sb_t  sb[$];
  sb_t  mon_e;

  div_bcd_readout #(.N(4), .DIGITS(2)) dut (
    .clock(clock), .reset(reset), .in_done(in_done), .in_error(in_error),
    .q(q), .r(r), .busy(busy), .out_valid(out_valid), .out_error(out_error),
    .q_bcd(q_bcd), .r_bcd(r_bcd)
  );

  div_bcd_readout #(.N(8), .DIGITS(3)) dut8 (
    .clock(clock), .reset(reset), .in_done(in_done8), .in_error(in_error8),
    .q(q8), .r(r8), .busy(busy8), .out_valid(out_valid8), .out_error(out_error8),
    .q_bcd(q_bcd8), .r_bcd(r_bcd8)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for out_valid on the N=4 instance, counting edges and busy cycles
  task automatic wait_valid(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
      if (busy) busy_n++;
    end
  endtask

  function automatic logic [11:0] bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: compare each out_valid rise against the oldest expectation
  always @(negedge clock) begin
    if (out_valid === 1'b1 && !ov_prev) begin
      rises++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_q_bcd", 32'(q_bcd), 32'(mon_e.eq));
        chk("sb_r_bcd", 32'(r_bcd), 32'(mon_e.er));
        chk("sb_out_error", 32'(out_error), 32'(mon_e.err));
      end
    end
    ov_prev <= (out_valid === 1'b1);
  end

  initial begin
    int cyc, bn, r0;

    vecs[0] = '{4'd13, 4'd2,  8'h13, 8'h02};
    vecs[1] = '{4'd15, 4'd0,  8'h15, 8'h00};
    vecs[2] = '{4'd0,  4'd7,  8'h00, 8'h07};
    vecs[3] = '{4'd10, 4'd9,  8'h10, 8'h09};
    vecs[4] = '{4'd9,  4'd15, 8'h09, 8'h15};
    vecs[5] = '{4'd4,  4'd11, 8'h04, 8'h11};

    reset = 1'b1; in_done = 1'b0; in_error = 1'b0; q = '0; r = '0;
    in_done8 = 1'b0; in_error8 = 1'b0; q8 = '0; r8 = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_error", 32'(out_error), 32'd0);
    chk("rst_q_bcd", 32'(q_bcd), 32'd0);
    chk("rst_r_bcd", 32'(r_bcd), 32'd0);
    reset = 1'b0;
    tick();

    // Vector table: one conversion per record
    for (int i = 0; i < 6; i++) begin
      q = vecs[i].q; r = vecs[i].r; in_done = 1'b1;
      sb.push_back('{vecs[i].eq, vecs[i].er, 1'b0});
      wait_valid(cyc, bn);
      chk("latency", 32'(cyc), 32'd5);
      chk("busy_cycles", 32'(bn), 32'd4);
      in_done = 1'b0;
      tick();
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("idle_keep_q", 32'(q_bcd), 32'(vecs[i].eq));
    end

    // Divider error: immediate blank result, never busy
    in_error = 1'b1;
    sb.push_back('{8'hFF, 8'hFF, 1'b1});
    tick();
    chk("err_valid", 32'(out_valid), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    in_error = 1'b0;
    tick();
    chk("err_idle_valid", 32'(out_valid), 32'd0);
    chk("err_idle_error", 32'(out_error), 32'd0);
    chk("err_idle_keep", 32'(q_bcd), 32'hFF);

    // Simultaneous done and error: fault wins
    in_done = 1'b1; in_error = 1'b1; q = 4'd5; r = 4'd1;
    sb.push_back('{8'hFF, 8'hFF, 1'b1});
    tick();
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_valid", 32'(out_valid), 32'd1);
    in_done = 1'b0; in_error = 1'b0;
    tick();

    // Held-high done with operands changed mid-conversion
    q = 4'd9; r = 4'd3; in_done = 1'b1;
    sb.push_back('{8'h09, 8'h03, 1'b0});
    r0 = rises;
    tick(); tick();
    q = 4'd14; r = 4'd1;
    repeat (18) tick();
    chk("held_one_rise", 32'(rises - r0), 32'd1);
    chk("held_q_bcd", 32'(q_bcd), 32'h09);
    chk("held_valid", 32'(out_valid), 32'd1);
    in_done = 1'b0;
    tick();

    // done falling during SHIFT: completes, DONE for a single cycle
    q = 4'd12; r = 4'd6; in_done = 1'b1;
    sb.push_back('{8'h12, 8'h06, 1'b0});
    tick(); tick();
    in_done = 1'b0;
    wait_valid(cyc, bn);
    chk("drop_latency", 32'(cyc), 32'd3);
    tick();
    chk("drop_done_1cyc", 32'(out_valid), 32'd0);

    // Reset mid-SHIFT then a fresh conversion
    q = 4'd7; r = 4'd1; in_done = 1'b1;
    tick(); tick();
    reset = 1'b1; in_done = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_error", 32'(out_error), 32'd0);
    chk("mid_rst_q_bcd", 32'(q_bcd), 32'd0);
    chk("mid_rst_r_bcd", 32'(r_bcd), 32'd0);
    reset = 1'b0;
    tick();
    q = 4'd6; r = 4'd4; in_done = 1'b1;
    sb.push_back('{8'h06, 8'h04, 1'b0});
    wait_valid(cyc, bn);
    chk("post_rst_latency", 32'(cyc), 32'd5);
    in_done = 1'b0;
    tick();

    // Wide instance: N=8, DIGITS=3
    q8 = 8'd255; r8 = 8'd99; in_done8 = 1'b1;
    cyc = 0;
    while (!out_valid8 && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("n8_latency", 32'(cyc), 32'd9);
    chk("n8_q_bcd", 32'(q_bcd8), 32'(bcd3(255)));
    chk("n8_r_bcd", 32'(r_bcd8), 32'(bcd3(99)));
    chk("n8_error", 32'(out_error8), 32'd0);
    in_done8 = 1'b0;
    tick();
    q8 = 8'd170; r8 = 8'd8; in_done8 = 1'b1;
    cyc = 0;
    while (!out_valid8 && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("n8b_q_bcd", 32'(q_bcd8), 32'(bcd3(170)));
    chk("n8b_r_bcd", 32'(r_bcd8), 32'(bcd3(8)));
    in_done8 = 1'b0;
    tick(); tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
